out_fm_mem_port: RTL and testbench
==================================

Name: out_fm_mem_port

Overview:
- Synthesizable responder for the accelerator's output-feature-map memory interface; replaces the behavioural out_fm array and its read pipeline.
- Serves conv_tile read requests with a fixed 2-cycle read latency and accepts its write strobes.
- Adds a host load/dump port so out_fm can be initialised and results drained without simulation-only file I/O.
- Sits between conv_tile and on-chip BRAM; one instance per out_fm buffer.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- DEPTH, 8192, number of words (N*R*C = 16*32*16).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- acc_busy  in  1  convolution in progress; accelerator owns the port.
- out_fm_rd_addr  in  AW  accelerator read address, sampled every cycle.
- out_fm_rd_data  out  DW  read data, exactly 2 cycles after address.
- out_fm_wr_addr  in  AW  accelerator write address.
- out_fm_wr_data  in  DW  accelerator write data.
- out_fm_wr_ena  in  1  accelerator write strobe.
- host_req  in  1  host access request.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  AW  host address.
- host_wdata  in  DW  host write data.
- host_ready  out  1  host request accepted this cycle.
- host_rdata  out  DW  host read data.
- host_rvalid  out  1  host_rdata valid (one-cycle pulse).
- addr_err  out  1  sticky out-of-range flag.

Behaviour:
- Reset (rst=0, async): out_fm_rd_data=0, host_rdata=0, host_rvalid=0, addr_err=0, FSM=HOST. Memory contents are not cleared.
- FSM states and transitions:
  - HOST: host_ready = host_req & ~acc_busy (combinational). acc_busy=1 -> ACCEL next cycle.
  - ACCEL: host_ready=0. acc_busy=0 -> DRAIN.
  - DRAIN: host_ready=0; lasts 2 cycles so the accelerator read and write pipelines empty, then -> HOST. acc_busy=1 during DRAIN -> ACCEL.
- Accelerator read port:
  - Active in every state.
  - Memory is read at the cycle the address is presented, then registered twice. out_fm_rd_data(t+2) = mem[out_fm_rd_addr(t)].
  - The pipeline is fully pipelined: a new address every cycle.
- Accelerator write port:
  - Write occurs at posedge when out_fm_wr_ena=1, in any state.
  - A same-cycle read of the same address returns the OLD data (the default; see the optional feature).
- Host access:
  - Accepted only when host_ready=1.
  - Write: the memory updates at that posedge.
  - Read: host_rdata/host_rvalid are presented 2 cycles after acceptance. Host reads already accepted complete even if acc_busy rises.
- Port sharing: single physical write port.
  - The accelerator write has priority; host_ready is never 1 while an accelerator write is possible (acc_busy or DRAIN).
  - Accelerator reads and host reads share the read port. A host read accepted in HOST does not disturb out_fm_rd_data timing; it uses a separate registered output path.
- Address range:
  - Any address >= DEPTH sets addr_err (sticky until reset). A read of such an address returns 0; a write to it is dropped.
  - Index with the low ceil(log2(DEPTH)) bits only after the range check.
- Simultaneous events: acc_busy rising in the same cycle as host_req -> the request is not accepted; the host must hold it.

Optional Feature:
- Macro: OUT_FM_RAW_FWD_EN.
- Defined: if out_fm_wr_ena=1 and out_fm_wr_addr == out_fm_rd_addr in the same cycle, out_fm_wr_data is forwarded into the read pipeline, so the NEW data appears 2 cycles later.
- Undefined: OLD data is returned, as specified above.

Decomposition:
- Shared package: FSM state typedef (HOST, ACCEL, DRAIN), the RD_LAT=2 constant, and the DRAIN_CYCLES=2 constant.
- One sub-module, out_fm_ram_2r1w: the memory array with one write port, two read ports, and the 2-stage registered outputs.
- The top level holds the FSM, the range check, forwarding and host handshake.

Test Plan:
- Host load then dump: with acc_busy=0, write mem[i]=i+0x100 for i=0..15, then read 0..15 -> host_rvalid 2 cycles after each accept, host_rdata=0x100..0x10F.
- Accelerator read pipeline: acc_busy=1, present addresses 3,4,5 on consecutive cycles -> out_fm_rd_data=0x103,0x104,0x105 on cycles t+2..t+4.
- Arbitration: acc_busy=1 in the same cycle as host_req -> host_ready=0 throughout ACCEL. After acc_busy falls, host_ready stays 0 for 2 DRAIN cycles, then goes to 1.
- Same-cycle RAW at addr 7 (old 0x107, new 0xDEAD) -> rd_data=0x107 without the macro, 0xDEAD with OUT_FM_RAW_FWD_EN.
- Out of range: read addr 8192 -> rd_data=0 and addr_err=1. A write to 9000 leaves memory unchanged. addr_err stays 1 until rst=0.
- Reset mid-operation: assert rst=0 while reads are in flight -> outputs go to 0 immediately, FSM=HOST, and previously written memory contents survive.

Source files
------------

// File: rtl/out_fm_mem_port_pkg.sv
// Shared types and constants for the out_fm memory port.
// Optional build macro: OUT_FM_RAW_FWD_EN (same-cycle write-to-read forwarding).
package out_fm_mem_port_pkg;

  // Port ownership FSM: host owns the port, accelerator owns it, or the
  // accelerator pipelines are draining before the host gets it back.
  typedef enum logic [1:0] {
    ST_HOST  = 2'd0,
    ST_ACCEL = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Read latency of both read ports, in clock cycles.
  localparam int RD_LAT = 2;

  // Cycles spent in DRAIN before the host may access the memory again.
  localparam int DRAIN_CYCLES = 2;

endpackage

// File: rtl/out_fm_ram_2r1w.sv
// out_fm storage: one write port, two read ports, each read port followed by
// an RD_LAT-deep register pipeline. Port A serves the accelerator, port B the
// host. Each read port can be overridden with a substitute word (out-of-range
// zero, or forwarded write data) chosen by the top level.
module out_fm_ram_2r1w
  import out_fm_mem_port_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 8192,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [IW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [IW-1:0] i_a_addr,
  input  logic          i_a_ovr,
  input  logic [DW-1:0] i_a_ovr_data,
  output logic [DW-1:0] o_a_data,
  input  logic          i_b_en,
  input  logic [IW-1:0] i_b_addr,
  input  logic          i_b_zero,
  output logic [DW-1:0] o_b_data,
  output logic          o_b_valid
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_a_pipe [RD_LAT];
  logic [DW-1:0] r_b_pipe [RD_LAT];
  logic          r_b_vld  [RD_LAT];
  logic [DW-1:0] w_a_rd;
  logic [DW-1:0] w_b_rd;

  // Array reads happen in the cycle the address is presented; the array
  // content seen here is the pre-write value, giving old-data-on-collision.
  assign w_a_rd = i_a_ovr  ? i_a_ovr_data : r_mem[i_a_addr];
  assign w_b_rd = i_b_zero ? '0           : r_mem[i_b_addr];

  // Single write port; contents are deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Accelerator read pipeline: a new address every cycle, RD_LAT stages.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RD_LAT; i++) r_a_pipe[i] <= '0;
    end else begin
      r_a_pipe[0] <= w_a_rd;
      for (int i = 1; i < RD_LAT; i++) r_a_pipe[i] <= r_a_pipe[i-1];
    end
  end

  // Host read pipeline with a matching valid shift register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_b_pipe[i] <= '0;
        r_b_vld[i]  <= 1'b0;
      end
    end else begin
      r_b_pipe[0] <= i_b_en ? w_b_rd : r_b_pipe[0];
      r_b_vld[0]  <= i_b_en;
      for (int i = 1; i < RD_LAT; i++) begin
        r_b_pipe[i] <= r_b_vld[i-1] ? r_b_pipe[i-1] : r_b_pipe[i];
        r_b_vld[i]  <= r_b_vld[i-1];
      end
    end
  end

  assign o_a_data  = r_a_pipe[RD_LAT-1];
  assign o_b_data  = r_b_pipe[RD_LAT-1];
  assign o_b_valid = r_b_vld[RD_LAT-1];

endmodule

// File: rtl/out_fm_mem_port.sv
// Output-feature-map memory responder: serves conv_tile reads (2-cycle
// latency) and writes, plus a host load/dump port used while the accelerator
// is idle. Optional build macro: OUT_FM_RAW_FWD_EN forwards same-cycle
// accelerator write data into the accelerator read pipeline.
//
// Host handshake: a host request (host_req with host_we/host_addr/host_wdata)
// is taken at the rising edge of any cycle where host_ready=1; the host must
// hold the request unchanged until then. A read returns host_rdata with a
// one-cycle host_rvalid pulse RD_LAT cycles after acceptance.
module out_fm_mem_port
  import out_fm_mem_port_pkg::*;
#(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 8192
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          acc_busy,
  input  logic [AW-1:0] out_fm_rd_addr,
  output logic [DW-1:0] out_fm_rd_data,
  input  logic [AW-1:0] out_fm_wr_addr,
  input  logic [DW-1:0] out_fm_wr_data,
  input  logic          out_fm_wr_ena,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_ready,
  output logic [DW-1:0] host_rdata,
  output logic          host_rvalid,
  output logic          addr_err,
  output logic [1:0]    dbg_state
);

  localparam int IW  = $clog2(DEPTH);
  localparam int DCW = $clog2(DRAIN_CYCLES + 1);

  state_t           r_state, w_state_nxt;
  logic [DCW-1:0]   r_drain_cnt, w_drain_cnt_nxt;
  logic             r_addr_err;

  logic             w_rd_oor, w_wr_oor, w_host_oor;
  logic             w_acc_wr, w_host_wr, w_we;
  logic [IW-1:0]    w_waddr;
  logic [DW-1:0]    w_wdata;
  logic             w_fwd, w_a_ovr;
  logic [DW-1:0]    w_a_ovr_data;
  logic             w_host_rd;

  // Range checks on the full address before truncating to the array index.
  assign w_rd_oor   = out_fm_rd_addr >= AW'(DEPTH);
  assign w_wr_oor   = out_fm_wr_addr >= AW'(DEPTH);
  assign w_host_oor = host_addr      >= AW'(DEPTH);

  // FSM state and drain counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_HOST;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
    end
  end

  // Next-state logic and host handshake; host only served in HOST with the
  // accelerator idle in the same cycle.
  always_comb begin
    w_state_nxt     = r_state;
    w_drain_cnt_nxt = r_drain_cnt;
    host_ready      = 1'b0;
    unique case (r_state)
      ST_HOST: begin
        host_ready = host_req & ~acc_busy;
        if (acc_busy) w_state_nxt = ST_ACCEL;
      end
      ST_ACCEL: begin
        if (!acc_busy) begin
          w_state_nxt     = ST_DRAIN;
          w_drain_cnt_nxt = '0;
        end
      end
      ST_DRAIN: begin
        if (acc_busy) begin
          w_state_nxt = ST_ACCEL;
        end else if (r_drain_cnt == DCW'(DRAIN_CYCLES - 1)) begin
          w_state_nxt = ST_HOST;
        end else begin
          w_drain_cnt_nxt = r_drain_cnt + 1'b1;
        end
      end
      default: w_state_nxt = ST_HOST;
    endcase
  end

  // Sticky out-of-range flag over every address actually used this cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr_err <= 1'b0;
    end else if (w_rd_oor | (out_fm_wr_ena & w_wr_oor) |
                 (host_ready & w_host_oor)) begin
      r_addr_err <= 1'b1;
    end
  end

  // One physical write port: accelerator wins; out-of-range writes dropped.
  assign w_acc_wr  = out_fm_wr_ena & ~w_wr_oor;
  assign w_host_wr = host_ready & host_we & ~w_host_oor & ~out_fm_wr_ena;
  assign w_we      = w_acc_wr | w_host_wr;
  assign w_waddr   = out_fm_wr_ena ? out_fm_wr_addr[IW-1:0] : host_addr[IW-1:0];
  assign w_wdata   = out_fm_wr_ena ? out_fm_wr_data : host_wdata;

`ifdef OUT_FM_RAW_FWD_EN
  assign w_fwd = out_fm_wr_ena & ~w_wr_oor & (out_fm_wr_addr == out_fm_rd_addr);
`else
  assign w_fwd = 1'b0;
`endif

  // Accelerator read override: out-of-range reads return zero, otherwise
  // forwarded write data when forwarding is active.
  assign w_a_ovr      = w_rd_oor | w_fwd;
  assign w_a_ovr_data = w_rd_oor ? '0 : out_fm_wr_data;

  assign w_host_rd = host_ready & ~host_we;

  out_fm_ram_2r1w #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_ram (
    .clk          (clk),
    .rst          (rst),
    .i_we         (w_we),
    .i_waddr      (w_waddr),
    .i_wdata      (w_wdata),
    .i_a_addr     (out_fm_rd_addr[IW-1:0]),
    .i_a_ovr      (w_a_ovr),
    .i_a_ovr_data (w_a_ovr_data),
    .o_a_data     (out_fm_rd_data),
    .i_b_en       (w_host_rd),
    .i_b_addr     (host_addr[IW-1:0]),
    .i_b_zero     (w_host_oor),
    .o_b_data     (host_rdata),
    .o_b_valid    (host_rvalid)
  );

  assign addr_err  = r_addr_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_out_fm_mem_port.sv
// Directed bench for out_fm_mem_port: host load/dump, accelerator read
// pipeline, arbitration and drain, same-cycle RAW, out-of-range handling and
// asynchronous reset with memory retention.
module tb_out_fm_mem_port;
  import out_fm_mem_port_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          acc_busy;
  logic [AW-1:0] out_fm_rd_addr;
  logic [DW-1:0] out_fm_rd_data;
  logic [AW-1:0] out_fm_wr_addr;
  logic [DW-1:0] out_fm_wr_data;
  logic          out_fm_wr_ena;
  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_ready;
  logic [DW-1:0] host_rdata;
  logic          host_rvalid;
  logic          addr_err;
  logic [1:0]    dbg_state;

  out_fm_mem_port #(.AW(AW), .DW(DW), .DEPTH(8192)) dut (
    .clk            (clk),
    .rst            (rst),
    .acc_busy       (acc_busy),
    .out_fm_rd_addr (out_fm_rd_addr),
    .out_fm_rd_data (out_fm_rd_data),
    .out_fm_wr_addr (out_fm_wr_addr),
    .out_fm_wr_data (out_fm_wr_data),
    .out_fm_wr_ena  (out_fm_wr_ena),
    .host_req       (host_req),
    .host_we        (host_we),
    .host_addr      (host_addr),
    .host_wdata     (host_wdata),
    .host_ready     (host_ready),
    .host_rdata     (host_rdata),
    .host_rvalid    (host_rvalid),
    .addr_err       (addr_err),
    .dbg_state      (dbg_state)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp;
  } vec_t;

  vec_t dump_tbl [16];
  vec_t acc_tbl  [6];

  int n_checks = 0;
  int n_fail   = 0;

`ifdef OUT_FM_RAW_FWD_EN
  localparam logic [31:0] RAW_EXP = 32'h0000_DEAD;
`else
  localparam logic [31:0] RAW_EXP = 32'h0000_0107;
`endif

  // Scoreboard compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge (input drive point).
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] b2w(input logic b);
    return {31'd0, b};
  endfunction

  function automatic logic [31:0] s2w(input logic [1:0] s);
    return {30'd0, s};
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) begin
      dump_tbl[i].addr = i;
      dump_tbl[i].exp  = 32'h100 + i;
    end
    acc_tbl[0] = '{32'd3,    32'h103};
    acc_tbl[1] = '{32'd4,    32'h104};
    acc_tbl[2] = '{32'd5,    32'h105};
    acc_tbl[3] = '{32'd15,   32'h10F};
    acc_tbl[4] = '{32'd8191, 32'hCAFE};
    acc_tbl[5] = '{32'd0,    32'h100};

    acc_busy = 0; out_fm_rd_addr = 0; out_fm_wr_addr = 0; out_fm_wr_data = 0;
    out_fm_wr_ena = 0; host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;

    // Reset state
    @(negedge clk);
    chk("rst_rd_data", out_fm_rd_data, 32'h0);
    chk("rst_host_rdata", host_rdata, 32'h0);
    chk("rst_host_rvalid", b2w(host_rvalid), 32'h0);
    chk("rst_addr_err", b2w(addr_err), 32'h0);
    chk("rst_state", s2w(dbg_state), 32'(ST_HOST));
    step();
    rst = 1;
    step();

    // Host load: 0..15 plus the top word
    for (int i = 0; i < 17; i++) begin
      host_req = 1; host_we = 1;
      host_addr  = (i < 16) ? dump_tbl[i].addr : 32'd8191;
      host_wdata = (i < 16) ? dump_tbl[i].exp  : 32'hCAFE;
      @(negedge clk);
      chk($sformatf("load_ready[%0d]", i), b2w(host_ready), 32'h1);
      step();
    end
    host_req = 0; host_we = 0;

    // Host dump: rvalid/rdata two cycles after each accept
    for (int k = 0; k < 18; k++) begin
      if (k < 16) begin
        host_req = 1; host_we = 0; host_addr = dump_tbl[k].addr;
      end else begin
        host_req = 0;
      end
      @(negedge clk);
      if (k < 16) chk($sformatf("dump_ready[%0d]", k), b2w(host_ready), 32'h1);
      if (k >= 2) begin
        chk($sformatf("dump_rvalid[%0d]", k - 2), b2w(host_rvalid), 32'h1);
        chk($sformatf("dump_rdata[%0d]", k - 2), host_rdata, dump_tbl[k-2].exp);
      end else begin
        chk($sformatf("dump_rvalid_early[%0d]", k), b2w(host_rvalid), 32'h0);
      end
      step();
    end
    @(negedge clk);
    chk("dump_rvalid_end", b2w(host_rvalid), 32'h0);
    step();

    // acc_busy rises together with a host request: not accepted
    acc_busy = 1; host_req = 1; host_we = 0; host_addr = 0;
    @(negedge clk);
    chk("arb_ready_same_cycle", b2w(host_ready), 32'h0);
    step();

    // Accelerator read pipeline with host request held
    for (int k = 0; k < 8; k++) begin
      if (k < 6) out_fm_rd_addr = acc_tbl[k].addr;
      @(negedge clk);
      chk($sformatf("accel_state[%0d]", k), s2w(dbg_state), 32'(ST_ACCEL));
      chk($sformatf("accel_ready[%0d]", k), b2w(host_ready), 32'h0);
      if (k >= 2) chk($sformatf("accel_rd[%0d]", k - 2), out_fm_rd_data, acc_tbl[k-2].exp);
      step();
    end

    // Same-cycle read/write of address 7
    out_fm_rd_addr = 7; out_fm_wr_ena = 1; out_fm_wr_addr = 7; out_fm_wr_data = 32'hDEAD;
    step();
    out_fm_wr_ena = 0;
    step();
    out_fm_rd_addr = 0;
    @(negedge clk);
    chk("raw_same_cycle", out_fm_rd_data, RAW_EXP);
    step();
    @(negedge clk);
    chk("raw_after_write", out_fm_rd_data, 32'hDEAD);
    step();

    // Out-of-range read and writes
    out_fm_rd_addr = 8192;
    @(negedge clk);
    chk("oor_err_before", b2w(addr_err), 32'h0);
    step();
    out_fm_rd_addr = 0; out_fm_wr_ena = 1; out_fm_wr_addr = 9000; out_fm_wr_data = 32'hBAD;
    @(negedge clk);
    chk("oor_err_set", b2w(addr_err), 32'h1);
    step();
    out_fm_wr_addr = 8197;
    @(negedge clk);
    chk("oor_rd_zero", out_fm_rd_data, 32'h0);
    step();
    out_fm_wr_ena = 0; out_fm_rd_addr = 5;
    step();
    out_fm_rd_addr = 9000;
    step();
    out_fm_rd_addr = 0;
    @(negedge clk);
    chk("oor_no_alias_write", out_fm_rd_data, 32'h105);
    step();
    @(negedge clk);
    chk("oor_rd_zero_9000", out_fm_rd_data, 32'h0);
    chk("oor_err_sticky", b2w(addr_err), 32'h1);
    step();

    // acc_busy falls: two DRAIN cycles, then host gets the port
    acc_busy = 0; host_req = 1; host_we = 0; host_addr = 1;
    @(negedge clk);
    chk("drain_x0_state", s2w(dbg_state), 32'(ST_ACCEL));
    chk("drain_x0_ready", b2w(host_ready), 32'h0);
    step();
    for (int d = 0; d < 2; d++) begin
      @(negedge clk);
      chk($sformatf("drain_state[%0d]", d), s2w(dbg_state), 32'(ST_DRAIN));
      chk($sformatf("drain_ready[%0d]", d), b2w(host_ready), 32'h0);
      step();
    end
    @(negedge clk);
    chk("drain_host_state", s2w(dbg_state), 32'(ST_HOST));
    chk("drain_host_ready", b2w(host_ready), 32'h1);
    step();
    host_req = 0;
    @(negedge clk);
    chk("drain_rd_rvalid_lat1", b2w(host_rvalid), 32'h0);
    step();
    @(negedge clk);
    chk("drain_rd_rvalid", b2w(host_rvalid), 32'h1);
    chk("drain_rd_rdata", host_rdata, 32'h101);
    step();

    // acc_busy during DRAIN returns to ACCEL
    acc_busy = 1;
    step();
    acc_busy = 0;
    step();
    acc_busy = 1;
    @(negedge clk);
    chk("redrain_state", s2w(dbg_state), 32'(ST_DRAIN));
    step();
    acc_busy = 0;
    @(negedge clk);
    chk("redrain_back_accel", s2w(dbg_state), 32'(ST_ACCEL));
    step();
    step();
    step();
    @(negedge clk);
    chk("redrain_host", s2w(dbg_state), 32'(ST_HOST));
    step();

    // Host read completes even when acc_busy rises right after acceptance
    host_req = 1; host_we = 0; host_addr = 2;
    @(negedge clk);
    chk("inflight_ready", b2w(host_ready), 32'h1);
    step();
    host_req = 0; acc_busy = 1;
    step();
    @(negedge clk);
    chk("inflight_rvalid", b2w(host_rvalid), 32'h1);
    chk("inflight_rdata", host_rdata, 32'h102);
    chk("inflight_state", s2w(dbg_state), 32'(ST_ACCEL));
    step();

    // Asynchronous reset with reads in flight
    out_fm_rd_addr = 3;
    step();
    step();
    step();
    @(negedge clk);
    chk("prerst_rd", out_fm_rd_data, 32'h103);
    @(posedge clk);
    #2;
    rst = 0;
    #1;
    chk("midrst_rd_data", out_fm_rd_data, 32'h0);
    chk("midrst_host_rdata", host_rdata, 32'h0);
    chk("midrst_rvalid", b2w(host_rvalid), 32'h0);
    chk("midrst_addr_err", b2w(addr_err), 32'h0);
    chk("midrst_state", s2w(dbg_state), 32'(ST_HOST));
    acc_busy = 0;
    step();
    rst = 1;
    step();

    // Memory contents survive reset
    host_req = 1; host_we = 0; host_addr = 3;
    step();
    host_addr = 7;
    step();
    host_req = 0;
    @(negedge clk);
    chk("retain_rdata_3", host_rdata, 32'h103);
    chk("retain_rvalid_3", b2w(host_rvalid), 32'h1);
    step();
    @(negedge clk);
    chk("retain_rdata_7", host_rdata, 32'hDEAD);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
